// File: rtl/seq_divider_pkg.sv
// Shared definitions for the multi-cycle HI/LO divider: controller states and
// the default datapath width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// start/busy/done handshake between the pipeline (master) and the divider (slave).
interface seq_divider_if import seq_divider_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             is_signed;
  logic             cancel;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, cancel, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, cancel, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial
// subtract the divisor magnitude, keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;

  assign shifted_s = {rem_in, bit_in};
  // rem_in < divisor, so a non-borrowing difference always fits in WIDTH bits
  assign diff_s    = shifted_s[WIDTH-1:0] - divisor;
  assign q_bit     = (shifted_s >= {1'b0, divisor});
  assign rem_out   = q_bit ? diff_s : shifted_s[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider feeding HI (remainder) and LO
// (quotient); retires UNROLL quotient bits per CALC cycle.
module seq_divider import seq_divider_pkg::*; #(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  seq_divider_if.slave    bus
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  div_state_t       state_r;
  div_state_t       state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] dmag_r;
  logic [WIDTH-1:0] dividend_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             zero_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] remd_r;
  logic             dbz_r;

  logic             accept_s;
  logic [WIDTH-1:0] chain_s [0:UNROLL];
  logic [UNROLL-1:0] qbits_s;
  logic [WIDTH-1:0] sh_next_s;

  // Two's-complement magnitude; the most negative value maps to its unsigned bit pattern.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      magnitude = -v;
    end else begin
      magnitude = v;
    end
  endfunction

  assign accept_s = (state_r == IDLE) && bus.start && !bus.cancel;

  assign chain_s[0] = rem_r;

  genvar gi;
  generate
    for (gi = 0; gi < UNROLL; gi++) begin : g_step
      div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (chain_s[gi]),
        .bit_in  (sh_r[WIDTH-1-gi]),
        .divisor (dmag_r),
        .rem_out (chain_s[gi+1]),
        .q_bit   (qbits_s[UNROLL-1-gi])
      );
    end
  endgenerate

  // Consumed dividend bits leave the top while quotient bits fill in from the bottom.
  assign sh_next_s = (sh_r << UNROLL) | WIDTH'(qbits_s);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = (bus.divisor == {WIDTH{1'b0}}) ? FIX : CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_s = IDLE;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == CALC) || (state_s == FIX);
      done_r  <= (state_r == FIX) && !bus.cancel;
    end
  end

  // Operand capture and iterative datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= {CW{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      sh_r       <= {WIDTH{1'b0}};
      dmag_r     <= {WIDTH{1'b0}};
      dividend_r <= {WIDTH{1'b0}};
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      zero_r     <= 1'b0;
    end else if (accept_s) begin
      cnt_r      <= CW'(N - 1);
      rem_r      <= {WIDTH{1'b0}};
      sh_r       <= magnitude(bus.dividend, bus.is_signed);
      dmag_r     <= magnitude(bus.divisor, bus.is_signed);
      dividend_r <= bus.dividend;
      q_neg_r    <= bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      r_neg_r    <= bus.is_signed && bus.dividend[WIDTH-1];
      zero_r     <= (bus.divisor == {WIDTH{1'b0}});
    end else if (state_r == CALC) begin
      rem_r <= chain_s[UNROLL];
      sh_r  <= sh_next_s;
      if (cnt_r != {CW{1'b0}}) begin
        cnt_r <= cnt_r - CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result registers: sign-corrected in FIX, held otherwise (including on cancel).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_r <= {WIDTH{1'b0}};
      remd_r <= {WIDTH{1'b0}};
      dbz_r  <= 1'b0;
    end else if (accept_s) begin
      dbz_r <= 1'b0;
    end else if ((state_r == FIX) && !bus.cancel) begin
      if (zero_r) begin
        quot_r <= {WIDTH{1'b1}};
        remd_r <= dividend_r;
        dbz_r  <= 1'b1;
      end else begin
        quot_r <= q_neg_r ? -sh_r : sh_r;
        remd_r <= r_neg_r ? -rem_r : rem_r;
        dbz_r  <= 1'b0;
      end
    end else begin
      dbz_r <= dbz_r;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = remd_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: a cycle-level reference model of the divider handshake
// plus directed operations with hand-computed results, for UNROLL=1 and UNROLL=4.
module tb_seq_divider;

  logic        clk;
  logic [1:0]  rst_v;
  logic [1:0]  start_v;
  logic [1:0]  sg_v;
  logic [1:0]  cancel_v;
  logic [31:0] a_v [2];
  logic [31:0] b_v [2];

  logic [1:0]  busy_w;
  logic [1:0]  done_w;
  logic [1:0]  dbz_w;
  logic [31:0] q_w [2];
  logic [31:0] r_w [2];

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  seq_divider_if #(.WIDTH(32)) ia ();
  seq_divider_if #(.WIDTH(32)) ib ();

  seq_divider #(.WIDTH(32), .UNROLL(1)) dut_a (.clk(clk), .rst(rst_v[0]), .bus(ia));
  seq_divider #(.WIDTH(32), .UNROLL(4)) dut_b (.clk(clk), .rst(rst_v[1]), .bus(ib));

  assign ia.start = start_v[0];  assign ib.start = start_v[1];
  assign ia.is_signed = sg_v[0]; assign ib.is_signed = sg_v[1];
  assign ia.cancel = cancel_v[0]; assign ib.cancel = cancel_v[1];
  assign ia.dividend = a_v[0];   assign ib.dividend = a_v[1];
  assign ia.divisor = b_v[0];    assign ib.divisor = b_v[1];
  assign busy_w[0] = ia.busy;    assign busy_w[1] = ib.busy;
  assign done_w[0] = ia.done;    assign done_w[1] = ib.done;
  assign dbz_w[0] = ia.div_by_zero; assign dbz_w[1] = ib.div_by_zero;
  assign q_w[0] = ia.quotient;   assign q_w[1] = ib.quotient;
  assign r_w[0] = ia.remainder;  assign r_w[1] = ib.remainder;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Arithmetic reference: {div_by_zero, quotient, remainder}.
  function automatic logic [64:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (sg) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    q32 = q[31:0];
    r32 = r[31:0];
    return {1'b0, q32, r32};
  endfunction

  // Timeline model: done N+1 edges after acceptance (1 for divide-by-zero).
  logic        m_busy [2];
  logic        m_done [2];
  logic        m_z    [2];
  logic [31:0] m_q    [2];
  logic [31:0] m_r    [2];
  int          m_cnt  [2];
  logic [64:0] m_pend [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_v[k]) begin
        m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_z[k] <= 1'b0;
        m_q[k] <= 32'd0;   m_r[k] <= 32'd0;   m_cnt[k] <= 0;
      end else begin
        m_done[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (start_v[k] && !cancel_v[k]) begin
            m_busy[k] <= 1'b1;
            m_z[k]    <= 1'b0;
            m_pend[k] <= ref_div(sg_v[k], a_v[k], b_v[k]);
            m_cnt[k]  <= (b_v[k] == 32'd0) ? 1 : ((k == 0) ? 33 : 9);
          end
        end else if (cancel_v[k]) begin
          m_busy[k] <= 1'b0;
        end else if (m_cnt[k] == 1) begin
          m_busy[k] <= 1'b0;
          m_done[k] <= 1'b1;
          m_z[k]    <= m_pend[k][64];
          m_q[k]    <= m_pend[k][63:32];
          m_r[k]    <= m_pend[k][31:0];
        end else begin
          m_cnt[k] <= m_cnt[k] - 1;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (chk_en && !rst_v[k])
        check($sformatf("cycle_dut%0d", k),
              {busy_w[k], done_w[k], dbz_w[k], q_w[k], r_w[k]},
              {m_busy[k], m_done[k], m_z[k], m_q[k], m_r[k]});
    end
  end

  // Called at posedge+1; the next edge is the accepting edge 0.
  task automatic start_op(input int k, input logic sg, input logic [31:0] a, input logic [31:0] b);
    sg_v[k] = sg; a_v[k] = a; b_v[k] = b; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    a_v[k] = $urandom; b_v[k] = $urandom; sg_v[k] = ~sg;
  endtask

  task automatic wait_done(input int k, output int lat, output int bcnt);
    bit found;
    found = 1'b0; lat = 0; bcnt = 0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      if (done_w[k]) begin
        lat = e; found = 1'b1;
        break;
      end
      if (busy_w[k]) bcnt++;
    end
    check("done_timeout", {127'd0, found}, 128'd1);
  endtask

  task automatic expect_res(input string name, input int k, input logic [31:0] q,
                            input logic [31:0] r, input logic z);
    check(name, {dbz_w[k], q_w[k], r_w[k]}, {z, q, r});
  endtask

  int lat, bcnt, seen;

  initial begin
    rst_v = 2'b11; start_v = 2'b00; sg_v = 2'b00; cancel_v = 2'b00;
    a_v[0] = 32'd0; b_v[0] = 32'd0; a_v[1] = 32'd0; b_v[1] = 32'd0;
    #1;
    check("reset_a", {busy_w[0], done_w[0], dbz_w[0], q_w[0], r_w[0]}, 128'd0);
    check("reset_b", {busy_w[1], done_w[1], dbz_w[1], q_w[1], r_w[1]}, 128'd0);
    repeat (2) @(posedge clk);
    #1; rst_v = 2'b00; chk_en = 1'b1;

    // UNROLL=1: unsigned 100/7 with exact latency and busy window
    @(posedge clk); #1;
    start_op(0, 1'b0, 32'd100, 32'd7);
    wait_done(0, lat, bcnt);
    check("lat_100_7", 128'(lat), 128'd33);
    check("busy_edges_1_32", 128'(bcnt), 128'd32);
    expect_res("u_100_7", 0, 32'd14, 32'd2, 1'b0);
    @(posedge clk); #1;
    check("busy_low_after_done", {127'd0, busy_w[0]}, 128'd0);

    start_op(0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(0, lat, bcnt);
    expect_res("s_m7_2", 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    start_op(0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done(0, lat, bcnt);
    expect_res("s_7_m2", 0, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
    start_op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, lat, bcnt);
    expect_res("s_overflow", 0, 32'h8000_0000, 32'h0000_0000, 1'b0);
    start_op(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done(0, lat, bcnt);
    expect_res("u_max_1", 0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

    // divide by zero in both modes, then a valid op clears the flag
    start_op(0, 1'b0, 32'h0000_1234, 32'd0);
    wait_done(0, lat, bcnt);
    check("lat_dbz_u", 128'(lat), 128'd1);
    expect_res("dbz_u", 0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    @(posedge clk); #1;
    start_op(0, 1'b1, 32'h0000_1234, 32'd0);
    wait_done(0, lat, bcnt);
    check("lat_dbz_s", 128'(lat), 128'd1);
    expect_res("dbz_s", 0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    start_op(0, 1'b0, 32'd50, 32'd5);
    wait_done(0, lat, bcnt);
    expect_res("dbz_cleared", 0, 32'd10, 32'd0, 1'b0);

    // cancel sampled at edge 11: no done, results retained
    @(posedge clk); #1;
    start_op(0, 1'b0, 32'd777, 32'd3);
    repeat (10) @(posedge clk);
    #1; cancel_v[0] = 1'b1;
    @(posedge clk); #1; cancel_v[0] = 1'b0;
    check("cancel_busy_low", {127'd0, busy_w[0]}, 128'd0);
    expect_res("cancel_retained", 0, 32'd10, 32'd0, 1'b0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_w[0]) seen++;
    end
    check("cancel_no_done", 128'(seen), 128'd0);

    // start held high while busy is ignored
    start_op(0, 1'b0, 32'd1000, 32'd10);
    start_v[0] = 1'b1; a_v[0] = 32'd5; b_v[0] = 32'd1;
    repeat (20) @(posedge clk);
    #1; start_v[0] = 1'b0;
    wait_done(0, lat, bcnt);
    expect_res("start_while_busy", 0, 32'd100, 32'd0, 1'b0);
    // back-to-back: start issued in the done cycle
    start_op(0, 1'b0, 32'd12345, 32'd100);
    wait_done(0, lat, bcnt);
    check("lat_back_to_back", 128'(lat), 128'd33);
    expect_res("back_to_back", 0, 32'd123, 32'd45, 1'b0);

    // UNROLL=4
    start_op(1, 1'b0, 32'd1000, 32'd3);
    wait_done(1, lat, bcnt);
    check("lat_u4", 128'(lat), 128'd9);
    expect_res("u4_1000_3", 1, 32'd333, 32'd1, 1'b0);

    // async reset mid-CALC clears outputs without a clock edge
    @(posedge clk); #1;
    start_op(1, 1'b0, 32'd999, 32'd4);
    repeat (3) @(posedge clk);
    #1; rst_v[1] = 1'b1;
    #1;
    check("async_rst_b", {busy_w[1], done_w[1], dbz_w[1], q_w[1], r_w[1]}, 128'd0);
    @(posedge clk); #1; rst_v[1] = 1'b0;
    @(posedge clk); #1;
    start_op(1, 1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(1, lat, bcnt);
    check("lat_u4_after_rst", 128'(lat), 128'd9);
    expect_res("u4_m100_7", 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
